ads131_frame_decoder: RTL and testbench

Downstream consumer of the SPI master's bus signals (SPI_SCLK, SPI_CS, SPI_MISO) for the ADS131A0x ADC. It deserialises MISO on SCLK rising edges while CS is low and splits each frame into a status word plus NUM_CH channel samples. Samples are sign-extended to 24 bits and the assembled frame is presented on a valid/ready interface. Runs entirely in the system_clock domain; the SCLK, CS and MISO inputs are oversampled, not used as clocks.

---
 rtl/ads131_pkg.sv | 22 ++
 rtl/ads131_spi_rx_sync.sv | 73 +++++++
 rtl/ads131_frame_decoder.sv | 174 +++++++++++++++++
 tb/tb_ads131_frame_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ads131_pkg.sv
// Shared types, widths and helpers for the ADS131A0x frame decoder.
// Imported by the synchroniser and the decoder top.
package ads131_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    CS_WAIT = 2'd2
  } state_t;

  localparam int SAMPLE_BITS  = 24;
  localparam int STATUS_BITS  = 16;

  localparam int WORD_BITS_16 = 16;
  localparam int WORD_BITS_24 = 24;
  localparam int WORD_BITS_32 = 32;

  function automatic logic [SAMPLE_BITS-1:0] sign_extend16(input logic [15:0] value);
    return {{(SAMPLE_BITS-16){value[15]}}, value};
  endfunction

endpackage

// File: rtl/ads131_spi_rx_sync.sv
// Oversampling front end: identical synchroniser chains on sclk/cs/miso plus
// edge detectors; cs_fall is suppressed until cs has been seen high after reset.
module ads131_spi_rx_sync
  import ads131_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_sclk,
  input  logic spi_cs,
  input  logic spi_miso,
  output logic sclk_rise,
  output logic cs_fall,
  output logic cs_rise,
  output logic sync_cs,
  output logic sync_miso
);

  localparam int FLUSH_CYCLES = SYNC_STAGES + 1;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] miso_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic [2:0]             flush_q, flush_d;
  logic                   armed_q, armed_d;
  logic                   sync_sclk;
  logic                   flushed;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      miso_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q[0] <= spi_sclk;
      cs_sync_q[0]   <= spi_cs;
      miso_sync_q[0] <= spi_miso;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        cs_sync_q[i]   <= cs_sync_q[i-1];
        miso_sync_q[i] <= miso_sync_q[i-1];
      end
      sclk_prev_q <= sync_sclk;
      cs_prev_q   <= sync_cs;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  assign sync_sclk = sclk_sync_q[SYNC_STAGES-1];
  assign sync_cs   = cs_sync_q[SYNC_STAGES-1];
  assign sync_miso = miso_sync_q[SYNC_STAGES-1];
  assign flushed   = (flush_q == 3'(FLUSH_CYCLES));

  // The reset value of the chain is not a real pin level, so a CS-low period
  // already in progress at reset release must not look like a fresh cs_fall.
  always_comb begin
    flush_d = flushed ? flush_q : flush_q + 3'd1;
    armed_d = armed_q | (flushed & sync_cs & cs_prev_q);
  end

  assign sclk_rise = sync_sclk & ~sclk_prev_q;
  assign cs_rise   = sync_cs & ~cs_prev_q;
  assign cs_fall   = armed_q & ~sync_cs & cs_prev_q;

endmodule

// File: rtl/ads131_frame_decoder.sv
// ADS131A0x frame decoder: deserialises MISO on oversampled SCLK rises while CS
// is low and presents status plus 24-bit channel samples on a valid/ready port.
module ads131_frame_decoder
  import ads131_pkg::*;
#(
  parameter int WORD_BITS   = 24,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          system_clock,
  input  logic                          reset_n,
  input  logic                          spi_sclk,
  input  logic                          spi_cs,
  input  logic                          spi_miso,
  output logic [STATUS_BITS-1:0]        status_word,
  output logic [NUM_CH*SAMPLE_BITS-1:0] ch_data,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic                          frame_error,
  output logic                          overrun,
  output logic [7:0]                    bit_count
);

  localparam int         FRAME_BITS     = WORD_BITS * (NUM_CH + 1);
  localparam logic [7:0] FRAME_BITS_CNT = 8'(FRAME_BITS);

  if (WORD_BITS != WORD_BITS_16 && WORD_BITS != WORD_BITS_24 &&
      WORD_BITS != WORD_BITS_32) begin : g_bad_word_bits
    $error("ads131_frame_decoder: WORD_BITS must be 16, 24 or 32");
  end
  if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
    $error("ads131_frame_decoder: NUM_CH must be in 1..4");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync_stages
    $error("ads131_frame_decoder: SYNC_STAGES must be in 1..3");
  end

  logic sclk_rise;
  logic cs_fall;
  logic cs_rise;
  logic sync_cs;
  logic sync_miso;

  ads131_spi_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .clk      (system_clock),
    .reset_n  (reset_n),
    .spi_sclk (spi_sclk),
    .spi_cs   (spi_cs),
    .spi_miso (spi_miso),
    .sclk_rise(sclk_rise),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .sync_cs  (sync_cs),
    .sync_miso(sync_miso)
  );

  state_t                          state_q, state_d;
  logic [FRAME_BITS-1:0]           shift_q, shift_d;
  logic [7:0]                      bit_count_q, bit_count_d;
  logic                            frame_valid_q, frame_valid_d;
  logic                            frame_error_q, frame_error_d;
  logic                            overrun_q, overrun_d;
  logic [STATUS_BITS-1:0]          status_q, status_d;
  logic [NUM_CH*SAMPLE_BITS-1:0]   ch_data_q, ch_data_d;
  logic [NUM_CH*SAMPLE_BITS-1:0]   samples;
  logic                            latch;
  logic                            load;
  logic                            take_bit;

  // Word k+1 of the frame carries channel k; word 0 (status) arrives first.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam int WORD_MSB = FRAME_BITS - 1 - (gi + 1) * WORD_BITS;
    if (WORD_BITS == WORD_BITS_16) begin : g_w16
      assign samples[gi*SAMPLE_BITS +: SAMPLE_BITS] = sign_extend16(shift_q[WORD_MSB -: 16]);
    end else begin : g_w24_32
      // 32-bit words keep their top 24 bits; the low byte carries no sample data.
      assign samples[gi*SAMPLE_BITS +: SAMPLE_BITS] = shift_q[WORD_MSB -: SAMPLE_BITS];
    end
  end

  if (WORD_BITS > STATUS_BITS) begin : g_status_pad
    logic status_pad_unused;
    assign status_pad_unused = ^shift_q[FRAME_BITS-STATUS_BITS-1 -: (WORD_BITS-STATUS_BITS)];
  end

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_count_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      status_q      <= '0;
      ch_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_count_q   <= bit_count_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
      status_q      <= status_d;
      ch_data_q     <= ch_data_d;
    end
  end

  // A bit arriving together with cs_rise still belongs to the frame.
  assign take_bit = sclk_rise & (~sync_cs | cs_rise);

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_count_d   = bit_count_q;
    frame_error_d = 1'b0;
    latch         = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          bit_count_d = '0;
          shift_d     = '0;
          state_d     = RECEIVE;
        end
      end
      RECEIVE: begin
        if (bit_count_q == FRAME_BITS_CNT) begin
          latch = 1'b1;
          // CS may already be high if it rose alongside the final bit.
          state_d = sync_cs ? IDLE : CS_WAIT;
        end else begin
          if (take_bit) begin
            shift_d     = {shift_q[FRAME_BITS-2:0], sync_miso};
            bit_count_d = (bit_count_q == 8'hFF) ? bit_count_q : bit_count_q + 8'd1;
          end
          if (cs_rise && bit_count_d < FRAME_BITS_CNT) begin
            frame_error_d = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      CS_WAIT: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load          = latch & (~frame_valid_q | frame_ready);
    overrun_d     = latch & frame_valid_q & ~frame_ready;
    frame_valid_d = frame_valid_q;
    status_d      = status_q;
    ch_data_d     = ch_data_q;
    if (load) begin
      frame_valid_d = 1'b1;
      status_d      = shift_q[FRAME_BITS-1 -: STATUS_BITS];
      ch_data_d     = samples;
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
  end

  assign status_word = status_q;
  assign ch_data     = ch_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign bit_count   = bit_count_q;

endmodule

// File: tb/tb_ads131_frame_decoder.sv
// Bench for ads131_frame_decoder: three instances (24b/4ch, 16b/2ch, 32b/1ch)
// driven by a bit-level SPI model and checked against a frame-level scoreboard.
`timescale 1ns/1ps
module tb_ads131_frame_decoder;

  localparam int WB0 = 24, NC0 = 4, SS0 = 2;
  localparam int WB1 = 16, NC1 = 2, SS1 = 2;
  localparam int WB2 = 32, NC2 = 1, SS2 = 3;

  int wb [3] = '{WB0, WB1, WB2};
  int nc [3] = '{NC0, NC1, NC2};
  int ss [3] = '{SS0, SS1, SS2};

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  rst_n, sclk, cs, miso, ready;
  logic [2:0]  valid, err, ovr;
  logic [15:0] status_w [3];
  logic [7:0]  bcnt [3];
  logic [95:0] data0;
  logic [47:0] data1;
  logic [23:0] data2;
  logic [95:0] data_w [3];

  assign data_w[0] = data0;
  assign data_w[1] = {48'd0, data1};
  assign data_w[2] = {72'd0, data2};

  ads131_frame_decoder #(.WORD_BITS(WB0), .NUM_CH(NC0), .SYNC_STAGES(SS0)) u_dut0 (
    .system_clock(clk), .reset_n(rst_n[0]), .spi_sclk(sclk[0]), .spi_cs(cs[0]),
    .spi_miso(miso[0]), .status_word(status_w[0]), .ch_data(data0),
    .frame_valid(valid[0]), .frame_ready(ready[0]), .frame_error(err[0]),
    .overrun(ovr[0]), .bit_count(bcnt[0]));

  ads131_frame_decoder #(.WORD_BITS(WB1), .NUM_CH(NC1), .SYNC_STAGES(SS1)) u_dut1 (
    .system_clock(clk), .reset_n(rst_n[1]), .spi_sclk(sclk[1]), .spi_cs(cs[1]),
    .spi_miso(miso[1]), .status_word(status_w[1]), .ch_data(data1),
    .frame_valid(valid[1]), .frame_ready(ready[1]), .frame_error(err[1]),
    .overrun(ovr[1]), .bit_count(bcnt[1]));

  ads131_frame_decoder #(.WORD_BITS(WB2), .NUM_CH(NC2), .SYNC_STAGES(SS2)) u_dut2 (
    .system_clock(clk), .reset_n(rst_n[2]), .spi_sclk(sclk[2]), .spi_cs(cs[2]),
    .spi_miso(miso[2]), .status_word(status_w[2]), .ch_data(data2),
    .frame_valid(valid[2]), .frame_ready(ready[2]), .frame_error(err[2]),
    .overrun(ovr[2]), .bit_count(bcnt[2]));

  typedef struct {
    int          inst;
    logic [15:0] status;
    logic [95:0] data;
  } frame_t;

  frame_t      exp_q [$];
  int          checks = 0;
  int          failures = 0;
  int          exp_err [3] = '{0, 0, 0};
  int          obs_err [3] = '{0, 0, 0};
  int          exp_ovr [3] = '{0, 0, 0};
  int          obs_ovr [3] = '{0, 0, 0};
  int          nbits [3] = '{0, 0, 0};
  int          last_rise [3] = '{0, 0, 0};
  bit          armed [3] = '{1'b1, 1'b1, 1'b1};
  logic [15:0] last_status [3];
  logic [95:0] last_data [3];
  logic [31:0] words [5];
  logic [2:0]  valid_prev = '0, err_prev = '0, ovr_prev = '0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic int frame_bits(input int i);
    return wb[i] * (nc[i] + 1);
  endfunction

  // Sample value of a device word, computed as a signed integer.
  function automatic logic [23:0] model_sample(input int w_bits, input logic [31:0] w);
    int v;
    if (w_bits == 16) begin
      v = int'(w[15:0]);
      if (v >= 32768) v = v - 65536;
      return 24'(v);
    end else if (w_bits == 32) begin
      return 24'(w >> 8);
    end
    return w[23:0];
  endfunction

  function automatic void model_latch(input int i);
    frame_t f;
    f.inst   = i;
    f.status = 16'(words[0] >> (wb[i] - 16));
    f.data   = '0;
    for (int ch = 0; ch < nc[i]; ch++) f.data[ch*24 +: 24] = model_sample(wb[i], words[ch+1]);
    if (exp_q.size() > 0 && !ready[i]) exp_ovr[i]++;
    else exp_q.push_back(f);
  endfunction

  task automatic set_words(input logic [31:0] w0, w1, w2, w3, w4);
    words = '{w0, w1, w2, w3, w4};
  endtask

  task automatic send_bit(input int i, input logic b);
    miso[i] = b;
    tick(4);
    sclk[i] = 1'b1;
    last_rise[i] = cyc;
    tick(4);
    sclk[i] = 1'b0;
    nbits[i]++;
    if (armed[i] && nbits[i] == frame_bits(i)) model_latch(i);
  endtask

  task automatic cs_low(input int i);
    cs[i] = 1'b0;
    nbits[i] = 0;
    armed[i] = 1'b1;
    tick(8);
  endtask

  task automatic cs_high(input int i);
    tick(4);
    cs[i] = 1'b1;
    if (armed[i] && nbits[i] < frame_bits(i)) exp_err[i]++;
    tick(16);
  endtask

  task automatic send_frame(input int i, input int total_bits);
    logic [159:0] stream;
    int n;
    stream = '0;
    n = 0;
    for (int w = 0; w <= nc[i]; w++) begin
      for (int b = wb[i] - 1; b >= 0; b--) begin
        stream[159-n] = words[w][b];
        n++;
      end
    end
    cs_low(i);
    for (int k = 0; k < total_bits; k++) send_bit(i, (k < n) ? stream[159-k] : k[0]);
    cs_high(i);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n[i]) begin
        if (valid[i] && !valid_prev[i]) check("latency", 96'(cyc - last_rise[i]), 96'(ss[i] + 2));
        if (valid[i]) begin
          if (exp_q.size() == 0 || exp_q[0].inst != i) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: inst %0d valid with status %0h data %0h, none expected",
                     i, status_w[i], data_w[i]);
          end else begin
            check("status_word", 96'(status_w[i]), 96'(exp_q[0].status));
            check("ch_data", data_w[i], exp_q[0].data);
            if (ready[i]) begin
              last_status[i] = status_w[i];
              last_data[i]   = data_w[i];
              $display("frame inst=%0d status=%h ch_data=%h", i, status_w[i], data_w[i]);
              void'(exp_q.pop_front());
            end
          end
        end
        if (err[i]) begin
          obs_err[i]++;
          if (err_prev[i]) check("frame_error_width", 96'(err_prev[i]), 96'(0));
        end
        if (ovr[i]) begin
          obs_ovr[i]++;
          if (ovr_prev[i]) check("overrun_width", 96'(ovr_prev[i]), 96'(0));
        end
      end
      valid_prev[i] = valid[i] & rst_n[i];
      err_prev[i]   = err[i] & rst_n[i];
      ovr_prev[i]   = ovr[i] & rst_n[i];
    end
  end

  initial begin
    rst_n = '0;
    sclk  = '0;
    cs    = '1;
    miso  = '0;
    ready = '1;
    tick(5);
    rst_n = '1;
    tick(1);
    check("reset_valid", 96'(valid[0]), 96'(0));
    check("reset_error", 96'(err[0]), 96'(0));
    check("reset_overrun", 96'(ovr[0]), 96'(0));
    check("reset_bit_count", 96'(bcnt[0]), 96'(0));
    check("reset_status", 96'(status_w[0]), 96'(0));
    check("reset_ch_data", data_w[0], 96'(0));
    tick(10);

    // 1: full 24-bit frame with extreme sample values
    set_words(32'h220000, 32'h7FFFFF, 32'h800000, 32'h000001, 32'hFFFFFF);
    send_frame(0, 120);
    check("t1_status", 96'(last_status[0]), 96'h2200);
    check("t1_ch_data", last_data[0], 96'hFFFFFF_000001_800000_7FFFFF);
    check("t1_no_error", 96'(obs_err[0]), 96'(0));
    check("t1_no_overrun", 96'(obs_ovr[0]), 96'(0));

    // 2: short frame of 50 bits
    set_words(32'h112233, 32'h445566, 32'h778899, 32'hAABBCC, 32'hDDEEFF);
    send_frame(0, 50);
    check("t2_error_pulses", 96'(obs_err[0]), 96'(1));
    check("t2_bit_count", 96'(bcnt[0]), 96'(50));
    check("t2_valid", 96'(valid[0]), 96'(0));

    // 3: backpressure, second frame dropped with overrun
    ready[0] = 1'b0;
    set_words(32'h330000, 32'h0000AA, 32'h0000BB, 32'h0000CC, 32'h0000DD);
    send_frame(0, 120);
    set_words(32'h440000, 32'h000055, 32'h000066, 32'h000077, 32'h000088);
    send_frame(0, 120);
    check("t3_overrun_pulses", 96'(obs_ovr[0]), 96'(1));
    check("t3_held_ch0", 96'(data0[23:0]), 96'h0000AA);
    check("t3_held_valid", 96'(valid[0]), 96'(1));
    ready[0] = 1'b1;
    tick(1);
    check("t3_valid_drop", 96'(valid[0]), 96'(0));
    check("t3_transferred_status", 96'(last_status[0]), 96'h3300);

    // 4: 16-bit words, two channels, sign extension
    set_words(32'hABCD, 32'h8001, 32'h7FFF, 32'h0, 32'h0);
    send_frame(1, 48);
    check("t4_status", 96'(last_status[1]), 96'hABCD);
    check("t4_ch_data", last_data[1], 96'h007FFF_FF8001);

    // 5: 32-bit words plus trailing SCLKs that must be ignored
    set_words(32'hC0DE0000, 32'h123456AB, 32'h0, 32'h0, 32'h0);
    send_frame(2, 72);
    check("t5_status", 96'(last_status[2]), 96'hC0DE);
    check("t5_ch0", last_data[2], 96'h123456);
    check("t5_no_error", 96'(obs_err[2]), 96'(0));
    check("t5_bit_count", 96'(bcnt[2]), 96'(64));

    // 6: reset at bit 40 with CS still low, then a fresh frame
    cs_low(0);
    for (int k = 0; k < 40; k++) send_bit(0, k[1]);
    rst_n[0] = 1'b0;
    tick(3);
    check("t6_reset_valid", 96'(valid[0]), 96'(0));
    check("t6_reset_bit_count", 96'(bcnt[0]), 96'(0));
    check("t6_reset_status", 96'(status_w[0]), 96'(0));
    check("t6_reset_ch_data", data_w[0], 96'(0));
    rst_n[0] = 1'b1;
    armed[0] = 1'b0;
    for (int k = 0; k < 20; k++) send_bit(0, 1'b1);
    check("t6_ignored_bit_count", 96'(bcnt[0]), 96'(0));
    check("t6_ignored_valid", 96'(valid[0]), 96'(0));
    cs_high(0);
    set_words(32'h5A5A00, 32'h000010, 32'hFFFF80, 32'h123456, 32'hABCDEF);
    send_frame(0, 120);
    check("t6_status", 96'(last_status[0]), 96'h5A5A);
    check("t6_ch_data", last_data[0], 96'hABCDEF_123456_FFFF80_000010);

    tick(10);
    for (int i = 0; i < 3; i++) begin
      check("error_count", 96'(obs_err[i]), 96'(exp_err[i]));
      check("overrun_count", 96'(obs_ovr[i]), 96'(exp_ovr[i]));
    end
    check("frames_outstanding", 96'(exp_q.size()), 96'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
